// File: rtl/mul_seq_pkg.sv
// Shared types and defaults for the iterative shift-add MUL sequencer.
package mul_seq_pkg;

   localparam int unsigned DEF_XLEN = 64;
   localparam int unsigned DEF_TAGW = 5;
   localparam int unsigned CNTW     = $clog2(DEF_XLEN);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } mul_state_e;

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-add datapath: accumulator, shifting multiplicand/multiplier, one shared adder.
module mul_shift_add_dp
   import mul_seq_pkg::*;
#(
   parameter int unsigned XLEN = DEF_XLEN
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load_i,
   input  logic            step_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic [XLEN-1:0] acc_o,
   output logic            b_next_zero_o
);

   logic [XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0] a_q, a_d;
   logic [XLEN-1:0] b_q, b_d;

   // acc_o is the post-step value so the controller can capture the final sum on the exit edge
   assign acc_o         = b_q[0] ? (acc_q + a_q) : acc_q;
   assign b_next_zero_o = (b_q[XLEN-1:1] == '0);

   always_comb begin
      acc_d = acc_q;
      a_d   = a_q;
      b_d   = b_q;
      if (load_i) begin
         acc_d = '0;
         a_d   = a_i;
         b_d   = b_i;
      end else if (step_i) begin
         acc_d = acc_o;
         a_d   = {a_q[XLEN-2:0], 1'b0};
         b_d   = {1'b0, b_q[XLEN-1:1]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         a_q   <= '0;
         b_q   <= '0;
      end else begin
         acc_q <= acc_d;
         a_q   <= a_d;
         b_q   <= b_d;
      end
   end

endmodule

// File: rtl/mul_sequencer.sv
// MUL controller for EX: accepts one request, iterates the shift-add datapath, pulses the result with its tag.
module mul_sequencer
   import mul_seq_pkg::*;
#(
   parameter int unsigned XLEN = DEF_XLEN,
   parameter int unsigned TAGW = DEF_TAGW
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [XLEN-1:0] req_a,
   input  logic [XLEN-1:0] req_b,
   input  logic [TAGW-1:0] req_rd,
   input  logic            flush,
   output logic            resp_valid,
   output logic [XLEN-1:0] resp_result,
   output logic [TAGW-1:0] resp_rd,
   output logic            stall
);

   localparam int unsigned CW = $clog2(XLEN);

   mul_state_e      state_q;
   logic [CW-1:0]   count_q;
   logic [TAGW-1:0] tag_q;
   logic            resp_valid_q;
   logic [XLEN-1:0] resp_result_q;
   logic [TAGW-1:0] resp_rd_q;

   logic            accept;
   logic            step;
   logic            b_next_zero;
   logic [XLEN-1:0] acc;

   assign req_ready = (state_q == ST_IDLE) && !flush;
   assign accept    = req_valid && req_ready;
   assign step      = (state_q == ST_BUSY) && !flush;
   assign stall     = (state_q == ST_BUSY) || (state_q == ST_DONE) ||
                      ((state_q == ST_IDLE) && req_valid && !flush);

   assign resp_valid  = resp_valid_q;
   assign resp_result = resp_result_q;
   assign resp_rd     = resp_rd_q;

   mul_shift_add_dp #(.XLEN(XLEN)) u_dp (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_i       (accept),
      .step_i       (step),
      .a_i          (req_a),
      .b_i          (req_b),
      .acc_o        (acc),
      .b_next_zero_o(b_next_zero)
   );

   // Response is registered on the edge entering DONE so it is visible for exactly the DONE cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         count_q       <= '0;
         tag_q         <= '0;
         resp_valid_q  <= 1'b0;
         resp_result_q <= '0;
         resp_rd_q     <= '0;
      end else begin
         resp_valid_q <= 1'b0;
         if (flush) begin
            state_q <= ST_IDLE;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (req_valid) begin
                     tag_q   <= req_rd;
                     count_q <= '0;
                     if (req_b == '0) begin
                        state_q       <= ST_DONE;
                        resp_valid_q  <= 1'b1;
                        resp_result_q <= '0;
                        resp_rd_q     <= req_rd;
                     end else begin
                        state_q <= ST_BUSY;
                     end
                  end
               end
               ST_BUSY: begin
                  count_q <= count_q + 1'b1;
                  if (b_next_zero || (count_q == CW'(XLEN - 1))) begin
                     state_q       <= ST_DONE;
                     resp_valid_q  <= 1'b1;
                     resp_result_q <= acc;
                     resp_rd_q     <= tag_q;
                  end
               end
               ST_DONE: state_q <= ST_IDLE;
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
- Iterative shift-add multiplier controller for the execute stage of the RV64 pipeline; handles MUL, which returns the low XLEN bits of the product.
- It reuses a single XLEN-bit adder across cycles rather than adding a combinational multiplier to the ALU path.
- It accepts one request at a time, stalls the pipeline while busy, and returns the result with the destination register tag.

Parameters:
XLEN, 64, operand/result width
TAGW, 5, destination register tag width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  EX stage presents a MUL
req_ready  out  1  sequencer can accept this cycle
req_a  in  XLEN  multiplicand (rs1 value)
req_b  in  XLEN  multiplier (rs2 value)
req_rd  in  TAGW  destination tag
flush  in  1  synchronous kill (branch mispredict/exception)
resp_valid  out  1  one-cycle result pulse
resp_result  out  XLEN  product mod 2^XLEN
resp_rd  out  TAGW  tag captured at accept
stall  out  1  hold IF/ID/EX stages

Behaviour:
- Reset (rst_n=0, async): state=IDLE; acc, a_reg, b_reg, tag and count are all 0; resp_valid=0; resp_result=0; resp_rd=0. Combinationally, req_ready=1 and stall=0.
- States: IDLE, BUSY, DONE.
- req_ready = (state==IDLE) && !flush.
- Accept = req_valid && req_ready.
- stall = (state==BUSY) || (state==DONE) || (state==IDLE && req_valid && !flush). stall is combinational.
- IDLE, on accept:
  - Latch a_reg=req_a, b_reg=req_b, tag=req_rd; acc=0; count=0.
  - If req_b==0, go to DONE. Otherwise go to BUSY.
- BUSY, each cycle:
  - If b_reg[0], acc = acc + a_reg (XLEN-bit, carry-out discarded).
  - a_reg <<= 1; b_reg >>= 1; count++.
  - Exit to DONE when the shifted b_reg==0 or count==XLEN-1 (early termination).
  - BUSY therefore lasts exactly msb_index(req_b)+1 cycles. Maximum is XLEN.
- DONE, one cycle:
  - resp_valid=1, resp_result=acc, resp_rd=tag. These are registered outputs.
  - Next state is IDLE.
  - resp_result and resp_rd hold their values after the pulse. resp_valid returns to 0.
- Back-to-back requests: a new request is accepted no earlier than the cycle after DONE. There is no accept during DONE.
- Latency: accept edge → resp_valid high after 1 + msb_index(b)+1 cycles for b≠0, and after 1 cycle for b=0.
- Signedness: only the low XLEN bits are produced, so the result is identical for signed and unsigned operands. MULH variants are out of scope.
- flush (synchronous, highest priority):
  - From any state, next state is IDLE and resp_valid=0 next cycle.
  - A flush in DONE suppresses nothing already emitted, because resp_valid in DONE is the current-cycle output. The DONE pulse is still seen; EX ignores a killed tag.
  - flush with req_valid in IDLE means no accept.
  - Datapath registers need not clear on flush.
- rst_n asserted mid-operation: immediate return to reset values. No response is produced.
- The same-cycle flush and accept conflict is covered by the flush rules above.

Decomposition:
- Package mul_seq_pkg:
  - state enum {IDLE, BUSY, DONE} (2-bit encoding);
  - XLEN and TAGW defaults;
  - count width constant CNTW=$clog2(XLEN).
- One natural sub-module, mul_shift_add_dp:
  - contents: acc/a_reg/b_reg registers and the adder;
  - controls: load and step strobes;
  - outputs: b_next_zero and acc.
- The FSM, count, tag, handshake and stall logic stay in mul_sequencer.

Test Plan:
- Reset mid-BUSY: accept a=7, b=0xFFFF_FFFF_FFFF_FFFF, then drop rst_n for 1 cycle on cycle 10. Outputs return to reset values, and no resp_valid appears for ≥70 cycles.
- Small operands: a=6, b=5, rd=3 → BUSY 3 cycles, resp_valid on the 4th cycle after accept, resp_result=30, resp_rd=3, stall high from the accept cycle through DONE.
- Zero multiplier: a=0x1234, b=0, rd=7 → resp_valid 1 cycle after accept, result=0, rd=7; one-cycle single stall beyond accept.
- Wrap and full latency:
  - Stimulus: a=0xFFFF_FFFF_FFFF_FFFF, b=0x8000_0000_0000_0000.
  - Required response: BUSY 64 cycles, result=0x8000_0000_0000_0000.
  - Then a=3, b=0xFFFF_FFFF_FFFF_FFFF → result=0xFFFF_FFFF_FFFF_FFFD.
- Flush:
  - Stimulus: accept a=9, b=9; assert flush on the 2nd BUSY cycle.
  - Required response: IDLE next cycle, no resp_valid, stall=0, req_ready=1.
  - Also flush with req_valid in IDLE → no accept, req_ready=0 that cycle.
- Back-to-back: hold req_valid=1 with a new request presented during DONE → not accepted until the following IDLE cycle. Both results are correct with the correct tags, in order.
